uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits per second.
REQ-003 Derived constants SHALL be MCNT_DIV = CLOCK_FREQ/BAUD_RATE - 1 (integer division) and HALF = MCNT_DIV/2.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_uart_rx  input  1  asynchronous serial line: idle high, 8N1, LSB first.
REQ-007 o_uart_data  output  8  last correctly framed byte.
REQ-008 o_uart_done  output  1  one-cycle pulse when o_uart_data is updated.
REQ-009 o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 i_uart_rx SHALL pass through a two-flop synchronizer; the second flop output is rx_s, and a third flop holds rx_prev.
REQ-012 The baud counter div_cnt SHALL be wide enough to hold MCNT_DIV, and SHALL clear to 0 on every state transition.
REQ-013 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 IDLE: a falling edge (rx_prev=1, rx_s=0) SHALL cause a move to START. No other condition SHALL leave IDLE.
REQ-015 START: when div_cnt==HALF, the block SHALL move to DATA if rx_s=0, and SHALL return to IDLE if rx_s=1 (glitch rejection, with no output pulse).
REQ-016 DATA: at each div_cnt==MCNT_DIV, rx_s SHALL be shifted into bit position bit_cnt (LSB first) and bit_cnt SHALL increment.
REQ-017 DATA: after the 8th sample, the block SHALL move to STOP and bit_cnt SHALL clear to 0.
REQ-018 STOP: at div_cnt==MCNT_DIV, if rx_s=1, o_uart_data SHALL load the shift register and o_uart_done SHALL be 1 for exactly the next cycle.
REQ-019 STOP: at div_cnt==MCNT_DIV, if rx_s=0, o_frame_err SHALL be 1 for exactly the next cycle and o_uart_data SHALL be unchanged.
REQ-020 STOP: at div_cnt==MCNT_DIV, the block SHALL return to IDLE regardless of the sampled value.
REQ-021 All samples SHALL fall at bit centre: start at HALF cycles, data and stop each MCNT_DIV+1 cycles after the previous sample.
REQ-022 Latency from the i_uart_rx falling edge to o_uart_done SHALL be 3 + (HALF+1) + 9*(MCNT_DIV+1) cycles, ±1.
REQ-023 o_uart_done and o_frame_err SHALL never be high in the same cycle, and each SHALL pulse at most once per frame.
REQ-024 o_uart_data SHALL hold its value between done pulses.
REQ-025 A new start edge SHALL be accepted in the first IDLE cycle after STOP (back-to-back frames, with no gap beyond the stop bit).
REQ-026 After a frame error on a line held low (break), no new frame SHALL start until rx_s has been seen high and then falls again.
REQ-027 Edges on i_uart_rx while the state is START, DATA or STOP SHALL be ignored except at sample points.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set: state=IDLE; div_cnt, bit_cnt and shift register = 0; o_uart_data=8'h00; o_uart_done=0; o_frame_err=0; o_busy=0.
REQ-029 While rst=1 at a clock edge, both synchronizer flops and rx_prev SHALL reset to 0, so a line held low out of reset is not taken as a start bit.
REQ-030 rst asserted mid-frame SHALL abort the frame with no done or error pulse.
REQ-031 rst asserted mid-frame SHALL leave o_uart_data at 8'h00.

Verification (bench parameters CLOCK_FREQ=160, BAUD_RATE=10, giving MCNT_DIV=15 and HALF=7)
REQ-032 Bench SHALL drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> o_uart_data=8'hA5 and a single o_uart_done pulse at 3+8+144 cycles ±1 after the start edge.
REQ-033 Bench SHALL drive 0x00 then 0xFF back-to-back with no idle gap -> two done pulses 160 cycles apart and data 8'h00 then 8'hFF.
REQ-034 Bench SHALL drive a 4-cycle low glitch on an idle line -> o_busy returns low within 12 cycles, with no done and no frame_err.
REQ-035 Bench SHALL drive frame 0x3C with the stop bit held low -> o_frame_err pulses once, o_uart_data keeps its prior value, and no new frame starts until the line goes high then low.
REQ-036 Bench SHALL assert rst during data bit 4 of a frame -> outputs return to reset values, no pulse occurs, and the next full frame 0x5A is received correctly.
REQ-037 Bench SHALL hold i_uart_rx low through reset and for 200 cycles after -> o_busy stays 0, and no done or frame_err occurs.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, centre-of-bit sampling,
// single-cycle done / frame-error pulses.
//
// state | meaning
// IDLE  | line idle, waiting for a high-to-low edge on rx_s
// START | counting to mid start bit, reject if line is back high
// DATA  | sampling 8 data bits LSB first at bit centres
// STOP  | sampling stop bit, publish byte or flag framing error
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_uart_data,
  output logic       o_uart_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int MCNT_DIV = CLOCK_FREQ / BAUD_RATE - 1;
  localparam int HALF     = MCNT_DIV / 2;
  localparam int CW       = (MCNT_DIV < 2) ? 1 : $clog2(MCNT_DIV + 1);

  localparam logic [CW-1:0] C_MCNT = CW'(MCNT_DIV);
  localparam logic [CW-1:0] C_HALF = CW'(HALF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_div_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_sync1;
  logic            r_rx_s;
  logic            r_rx_prev;

  logic            w_tick_half;
  logic            w_tick_full;
  logic            w_fall;
  logic            w_sample_bit;
  logic            w_done_set;
  logic            w_err_set;

  // Synchronisers reset low so a line held low out of reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_rx_s    <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync1   <= i_uart_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_tick_half = (r_div_cnt == C_HALF);
  assign w_tick_full = (r_div_cnt == C_MCNT);
  assign w_fall      = r_rx_prev & ~r_rx_s;

  // State register; the baud counter restarts on every transition and every full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_tick_full) begin
        r_div_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_div_cnt <= r_div_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_tick_half) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick_full && (r_bit_cnt == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_tick_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != S_IDLE);
    w_sample_bit = (r_state == S_DATA) && w_tick_full;
    w_done_set   = (r_state == S_STOP) && w_tick_full && r_rx_s;
    w_err_set    = (r_state == S_STOP) && w_tick_full && !r_rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      o_uart_data <= 8'h00;
      o_uart_done <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_uart_done <= w_done_set;
      o_frame_err <= w_err_set;
      if (w_sample_bit) begin
        r_shift[r_bit_cnt] <= r_rx_s;
        r_bit_cnt          <= (r_bit_cnt == 3'd7) ? 3'd0 : r_bit_cnt + 3'd1;
      end
      if (w_done_set) begin
        o_uart_data <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus
// hand sequences for glitch, break, reset-while-low and mid-frame reset.
module tb_uart_rx;

  localparam int BIT_CYC = 16;

  logic       clk;
  logic       rst;
  logic       i_uart_rx;
  logic [7:0] o_uart_data;
  logic       o_uart_done;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx #(.CLOCK_FREQ(160), .BAUD_RATE(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_uart_rx   (i_uart_rx),
    .o_uart_data (o_uart_data),
    .o_uart_done (o_uart_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  done_cnt = 0;
  int  err_cnt = 0;
  int  last_done_cyc = 0;
  int  prev_done_cyc = 0;
  bit  busy_seen = 1'b0;
  bit  overlap = 1'b0;

  always @(negedge clk) begin
    if (o_uart_done === 1'b1) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
    if (o_frame_err === 1'b1) err_cnt++;
    if (o_uart_done === 1'b1 && o_frame_err === 1'b1) overlap = 1'b1;
    if (o_busy === 1'b1) busy_seen = 1'b1;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int start_cyc;

  // Called on a negedge; returns on the negedge that ends the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = bits[i];
      wait_cyc(BIT_CYC);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
    bit         chk_b2b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d0, e0, lat;

    vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5, 1, 0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1, 0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 20, 8'hFF, 1, 0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 0,  8'hFF, 0, 1, 1'b0};

    // Line held low through reset and afterwards: must never start a frame.
    rst = 1'b1;
    i_uart_rx = 1'b0;
    wait_cyc(4);
    check("rst_data",  o_uart_data == 8'h00, int'(o_uart_data), 0);
    check("rst_done",  o_uart_done == 1'b0,  int'(o_uart_done), 0);
    check("rst_err",   o_frame_err == 1'b0,  int'(o_frame_err), 0);
    check("rst_busy",  o_busy == 1'b0,       int'(o_busy), 0);
    busy_seen = 1'b0;
    rst = 1'b0;
    wait_cyc(200);
    check("low_after_rst_busy", busy_seen == 1'b0, int'(busy_seen), 0);
    check("low_after_rst_done", done_cnt == 0, done_cnt, 0);
    check("low_after_rst_err",  err_cnt == 0, err_cnt, 0);

    i_uart_rx = 1'b1;
    wait_cyc(20);

    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      wait_cyc(vecs[v].gap);
      check($sformatf("v%0d_done", v), done_cnt - d0 == vecs[v].exp_done, done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_err", v),  err_cnt - e0 == vecs[v].exp_err,   err_cnt - e0,  vecs[v].exp_err);
      check($sformatf("v%0d_data", v), o_uart_data == vecs[v].exp_data, int'(o_uart_data), int'(vecs[v].exp_data));
      if (vecs[v].exp_done == 1) begin
        lat = last_done_cyc - start_cyc;
        check($sformatf("v%0d_latency", v), lat >= 154 && lat <= 156, lat, 155);
      end
      if (vecs[v].chk_b2b) begin
        check($sformatf("v%0d_b2b_spacing", v), last_done_cyc - prev_done_cyc == 160,
              last_done_cyc - prev_done_cyc, 160);
      end
    end

    // Break after the bad stop bit: line stays low, nothing may start.
    d0 = done_cnt;
    e0 = err_cnt;
    busy_seen = 1'b0;
    wait_cyc(100);
    check("break_busy", busy_seen == 1'b0, int'(busy_seen), 0);
    check("break_err",  err_cnt == e0, err_cnt - e0, 0);
    i_uart_rx = 1'b1;
    wait_cyc(20);
    send_frame(8'h96, 1'b1);
    wait_cyc(20);
    check("after_break_done", done_cnt - d0 == 1, done_cnt - d0, 1);
    check("after_break_data", o_uart_data == 8'h96, int'(o_uart_data), 8'h96);

    // Four-cycle low glitch on an idle line.
    d0 = done_cnt;
    e0 = err_cnt;
    busy_seen = 1'b0;
    i_uart_rx = 1'b0;
    wait_cyc(4);
    i_uart_rx = 1'b1;
    wait_cyc(8);
    check("glitch_busy_seen", busy_seen == 1'b1, int'(busy_seen), 1);
    check("glitch_busy_low",  o_busy == 1'b0, int'(o_busy), 0);
    wait_cyc(200);
    check("glitch_done", done_cnt == d0, done_cnt - d0, 0);
    check("glitch_err",  err_cnt == e0, err_cnt - e0, 0);
    check("glitch_data", o_uart_data == 8'h96, int'(o_uart_data), 8'h96);

    // Reset in the middle of data bit 4 of a 0x5A frame.
    d0 = done_cnt;
    e0 = err_cnt;
    i_uart_rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      i_uart_rx = (8'h5A >> i) & 1;
      wait_cyc(BIT_CYC);
    end
    i_uart_rx = 1'b1;
    wait_cyc(8);
    check("midrst_busy_before", o_busy == 1'b1, int'(o_busy), 1);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    check("midrst_data", o_uart_data == 8'h00, int'(o_uart_data), 0);
    check("midrst_busy", o_busy == 1'b0, int'(o_busy), 0);
    wait_cyc(150);
    check("midrst_done", done_cnt == d0, done_cnt - d0, 0);
    check("midrst_err",  err_cnt == e0, err_cnt - e0, 0);
    check("midrst_hold", o_uart_data == 8'h00, int'(o_uart_data), 0);
    send_frame(8'h5A, 1'b1);
    wait_cyc(20);
    check("post_rst_done", done_cnt - d0 == 1, done_cnt - d0, 1);
    check("post_rst_data", o_uart_data == 8'h5A, int'(o_uart_data), 8'h5A);
    lat = last_done_cyc - start_cyc;
    check("post_rst_latency", lat >= 154 && lat <= 156, lat, 155);

    check("done_err_overlap", overlap == 1'b0, int'(overlap), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
